// File: rtl/fact_pkg.sv
// Shared definitions for the factor-selection input block: game-state codes,
// the selection FSM state type and the default top selection code.
package fact_pkg;

   localparam logic [3:0] ST_READY = 4'b0010;
   localparam logic [3:0] ST_INPUT = 4'b0100;
   localparam int         DIN_MAX  = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      CMT  = 2'd2,
      REL  = 2'd3
   } fsm_t;

endpackage

// File: rtl/btn_debounce.sv
// Active-low push-button conditioner: 2-FF synchroniser followed by a
// stability counter; emits the clean pressed level and a one-cycle press pulse.
module btn_debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic level,
   output logic press
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic          sync1, sync2;
   logic [CW-1:0] cnt;
   logic          sample;

   // Synchroniser resets to the released (high) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   assign sample = ~sync2;

   // The DEB_CYCLES-th consecutive differing sample commits the new level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else if (sample != level) begin
         if (cnt == CW'(DEB_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sample;
            press <= sample;
         end else begin
            cnt   <= cnt + 1'b1;
            press <= 1'b0;
         end
      end else begin
         cnt   <= '0;
         press <= 1'b0;
      end
   end

endmodule

// File: rtl/factor_sel_input.sv
// Player-side selection of the 4-bit DIN code with commit handshake to the game FSM.
// Optional auto-repeat on held up/down buttons is enabled by FACT_AUTOREPEAT_EN.
module factor_sel_input #(
   parameter int         DEB_CYCLES = 50000,
   parameter int         DIN_MAX    = fact_pkg::DIN_MAX,
   parameter logic [3:0] ST_INPUT   = fact_pkg::ST_INPUT,
   parameter int         REPEAT_DLY = 25000000,
   parameter int         REPEAT_PER = 10000000
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic [3:0] STATE,
   input  logic       nBTN_UP,
   input  logic       nBTN_DN,
   input  logic       nBTN_OK,
   input  logic       CMT_ACK,
   output logic [3:0] DIN,
   output logic       CMT_REQ,
   output logic [3:0] CMT_DIN,
   output logic       BUSY
);

   import fact_pkg::*;

   fsm_t       st, st_n;
   logic [3:0] din_n, cdin_n, din_inc, din_dec;
   logic       req_n;
   logic       up_lvl, up_p, dn_lvl, dn_p, ok_lvl, ok_p;
   logic       up_step, dn_step;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .clk(CLK), .rst_n(nRST), .btn_n(nBTN_UP), .level(up_lvl), .press(up_p));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
      .clk(CLK), .rst_n(nRST), .btn_n(nBTN_DN), .level(dn_lvl), .press(dn_p));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
      .clk(CLK), .rst_n(nRST), .btn_n(nBTN_OK), .level(ok_lvl), .press(ok_p));

`ifdef FACT_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_DLY + 1);

   logic [1:0][RW-1:0] hold_cnt;
   logic [1:0]         rep, held;

   assign held = {dn_lvl, up_lvl};

   always_comb begin
      rep = '0;
      for (int i = 0; i < 2; i++)
         rep[i] = (st == SEL) && held[i] && (hold_cnt[i] == RW'(REPEAT_DLY));
   end

   // After the first repeat the counter restarts so the next one lands REPEAT_PER later.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hold_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (st != SEL || !held[i])
               hold_cnt[i] <= '0;
            else if (rep[i])
               hold_cnt[i] <= RW'(REPEAT_DLY - REPEAT_PER + 1);
            else
               hold_cnt[i] <= hold_cnt[i] + 1'b1;
         end
      end
   end

   assign up_step = up_p | rep[0];
   assign dn_step = dn_p | rep[1];
`else
   localparam int unused_rep = REPEAT_DLY + REPEAT_PER;
   logic unused_lvl;
   assign unused_lvl = up_lvl ^ dn_lvl;

   assign up_step = up_p;
   assign dn_step = dn_p;
`endif

   assign din_inc = (DIN == 4'(DIN_MAX)) ? 4'd0 : DIN + 4'd1;
   assign din_dec = (DIN == 4'd0) ? 4'(DIN_MAX) : DIN - 4'd1;

   always_comb begin
      st_n   = st;
      din_n  = DIN;
      req_n  = CMT_REQ;
      cdin_n = CMT_DIN;
      if (STATE != ST_INPUT) begin
         st_n  = IDLE;
         req_n = 1'b0;
      end else begin
         case (st)
            IDLE: st_n = SEL;
            SEL: begin
               // OK has priority; simultaneous up+down cancel out.
               if (ok_p) begin
                  cdin_n = DIN;
                  req_n  = 1'b1;
                  st_n   = CMT;
               end else if (up_step && !dn_step) begin
                  din_n = din_inc;
               end else if (dn_step && !up_step) begin
                  din_n = din_dec;
               end
            end
            CMT: begin
               if (CMT_ACK) begin
                  req_n = 1'b0;
                  din_n = 4'd0;
                  st_n  = REL;
               end
            end
            REL: if (!ok_lvl) st_n = SEL;
            default: st_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         st      <= IDLE;
         DIN     <= 4'd0;
         CMT_REQ <= 1'b0;
         CMT_DIN <= 4'd0;
      end else begin
         st      <= st_n;
         DIN     <= din_n;
         CMT_REQ <= req_n;
         CMT_DIN <= cdin_n;
      end
   end

   assign BUSY = (st == CMT) || (st == REL);

endmodule

// File: tb/tb_factor_sel_input.sv
// Directed bench for factor_sel_input with short debounce/repeat timing;
// expectations are hand-computed from button latency (6 cycles to pulse, 7 to DIN).
module tb_factor_sel_input;

   logic       CLK = 1'b0;
   logic       nRST;
   logic [3:0] STATE;
   logic       nBTN_UP, nBTN_DN, nBTN_OK, CMT_ACK;
   logic [3:0] DIN, CMT_DIN;
   logic       CMT_REQ, BUSY;

   int vecs = 0;
   int errs = 0;

   factor_sel_input #(
      .DEB_CYCLES(4), .DIN_MAX(9), .ST_INPUT(4'b0100),
      .REPEAT_DLY(20), .REPEAT_PER(8)
   ) dut (
      .CLK(CLK), .nRST(nRST), .STATE(STATE),
      .nBTN_UP(nBTN_UP), .nBTN_DN(nBTN_DN), .nBTN_OK(nBTN_OK),
      .CMT_ACK(CMT_ACK), .DIN(DIN), .CMT_REQ(CMT_REQ),
      .CMT_DIN(CMT_DIN), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Press the selected buttons together, then release and let the level settle.
   task automatic press(input logic u, input logic d, input logic o);
      nBTN_UP = ~u;
      nBTN_DN = ~d;
      nBTN_OK = ~o;
      tick(8);
      nBTN_UP = 1'b1;
      nBTN_DN = 1'b1;
      nBTN_OK = 1'b1;
      tick(8);
   endtask

   initial begin
      nRST = 1'b0; STATE = 4'b0100; CMT_ACK = 1'b0;
      nBTN_UP = 1'b0; nBTN_DN = 1'b1; nBTN_OK = 1'b1;
      tick(3);
      chk("rst_din", DIN, 0);
      chk("rst_req", CMT_REQ, 0);
      chk("rst_cdin", CMT_DIN, 0);
      chk("rst_busy", BUSY, 0);
      nRST = 1'b1;
      tick(6);
      chk("rst_press_t6", DIN, 0);
      tick(1);
      chk("rst_press_t7", DIN, 1);
      nBTN_UP = 1'b1;
      tick(8);
      chk("release_no_step", DIN, 1);

      // bounce rejection from a fresh reset
      nRST = 1'b0;
      tick(1);
      chk("rst2_din", DIN, 0);
      nRST = 1'b1;
      tick(2);
      for (int i = 0; i < 10; i++) begin
         nBTN_UP = ~nBTN_UP;
         tick(2);
      end
      nBTN_UP = 1'b1;
      tick(2);
      chk("bounce_reject", DIN, 0);
      press(1'b1, 1'b0, 1'b0);
      chk("bounce_settle", DIN, 1);

      // wrap in both directions
      press(1'b0, 1'b1, 1'b0);
      chk("dn_1_0", DIN, 0);
      press(1'b0, 1'b1, 1'b0);
      chk("dn_wrap", DIN, 9);
      press(1'b1, 1'b0, 1'b0);
      chk("up_wrap", DIN, 0);
      press(1'b0, 1'b1, 1'b0);
      chk("dn_wrap2", DIN, 9);
      for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0);
      chk("up_to_3", DIN, 3);
      press(1'b1, 1'b1, 1'b0);
      chk("up_dn_cancel", DIN, 3);

      // commit handshake with OK held through REL
      nBTN_OK = 1'b0;
      tick(8);
      chk("cmt_req", CMT_REQ, 1);
      chk("cmt_din", CMT_DIN, 3);
      chk("cmt_busy", BUSY, 1);
      nBTN_UP = 1'b0;
      tick(8);
      nBTN_UP = 1'b1;
      tick(8);
      chk("cmt_up_ignored", DIN, 3);
      chk("cmt_req_held", CMT_REQ, 1);
      CMT_ACK = 1'b1;
      tick(1);
      CMT_ACK = 1'b0;
      chk("ack_req", CMT_REQ, 0);
      chk("ack_din", DIN, 0);
      chk("ack_cdin", CMT_DIN, 3);
      tick(5);
      chk("rel_busy", BUSY, 1);
      nBTN_OK = 1'b1;
      tick(8);
      chk("rel_done", BUSY, 0);
      press(1'b1, 1'b0, 1'b0);
      chk("sel_again", DIN, 1);

      // OK with up in the same cycle: OK wins
      press(1'b1, 1'b0, 1'b1);
      chk("ok_wins_din", DIN, 1);
      chk("ok_wins_req", CMT_REQ, 1);
      chk("ok_wins_cdin", CMT_DIN, 1);

      // leaving the input state during CMT
      STATE = 4'b0010;
      tick(1);
      chk("exit_req", CMT_REQ, 0);
      chk("exit_busy", BUSY, 0);
      chk("exit_din", DIN, 1);
      for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
      chk("gated_up", DIN, 1);

      // ACK outside CMT is ignored
      STATE = 4'b0100;
      tick(2);
      CMT_ACK = 1'b1;
      tick(1);
      CMT_ACK = 1'b0;
      chk("stray_ack_din", DIN, 1);
      chk("stray_ack_req", CMT_REQ, 0);

      // long hold: single step unless auto-repeat is built in
      nBTN_UP = 1'b0;
      tick(42);
`ifdef FACT_AUTOREPEAT_EN
      chk("hold_up", DIN, 4);
`else
      chk("hold_up", DIN, 2);
`endif
      nBTN_UP = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/factor_sel_input.md
Name: factor_sel_input

Overview:
- Player-side producer of the 4-bit DIN selection code that the 7-segment digit decoder renders during the INPUT game state.
- Debounces three raw push-buttons (up, down, OK) and steps a 0..DIN_MAX selection index with wrap-around.
- On OK, raises a commit request to the game FSM, holds it until acknowledged, then waits for button release.
- Sits between the board push-buttons and the game-state FSM / segment decoder.

Parameters:
- DEB_CYCLES, 50000: consecutive stable samples required before a button level is accepted (1 ms at 50 MHz).
- DIN_MAX, 9: highest valid selection code; the index wraps DIN_MAX <-> 0.
- ST_INPUT, 4'b0100: STATE encoding in which input is enabled.
- REPEAT_DLY, 25000000: hold time before auto-repeat starts (optional feature only).
- REPEAT_PER, 10000000: auto-repeat period (optional feature only).

Ports:
- CLK, in, 1: system clock.
- nRST, in, 1: asynchronous active-low reset.
- STATE, in, 4: current game state from the game FSM.
- nBTN_UP, in, 1: raw up button, active-low, asynchronous to CLK.
- nBTN_DN, in, 1: raw down button, active-low, asynchronous to CLK.
- nBTN_OK, in, 1: raw commit button, active-low, asynchronous to CLK.
- CMT_ACK, in, 1: game FSM acknowledge of a commit.
- DIN, out, 4: live selection code to the segment decoder.
- CMT_REQ, out, 1: commit request, held high until acknowledged.
- CMT_DIN, out, 4: selection value captured at commit.
- BUSY, out, 1: high in states CMT and REL.

Behaviour:
- Reset (async, nRST=0): DIN=0, CMT_REQ=0, CMT_DIN=0, BUSY=0, FSM=IDLE, debouncers report "released".
- Synchronisation: each raw button passes through a 2-FF synchroniser before its debouncer.
- Debounce: the clean level changes only after DEB_CYCLES consecutive equal samples. A press pulse is one cycle wide on the released->pressed transition of the clean level. Release never generates a pulse.
- Latency: a raw press to its press pulse takes 2 + DEB_CYCLES cycles; the DIN update follows one cycle later.
- FSM states:
  - IDLE: entered whenever STATE != ST_INPUT; ignores all press pulses; DIN holds its value. Goes to SEL when STATE == ST_INPUT.
  - SEL: up pulse gives DIN = (DIN==DIN_MAX) ? 0 : DIN+1. Down pulse gives DIN = (DIN==0) ? DIN_MAX : DIN-1. Up and down pulsing in the same cycle: no change. OK pulse: CMT_DIN <= DIN, CMT_REQ <= 1, go to CMT. OK in the same cycle as up/down: OK wins and DIN stays unchanged.
  - CMT: CMT_REQ stays high and up/down are ignored. On CMT_ACK=1: CMT_REQ <= 0 the next cycle and DIN <= 0, go to REL.
  - REL: waits until the clean OK level is released, then returns to SEL.
- Exit to IDLE: STATE leaving ST_INPUT in any state forces IDLE next cycle, clears CMT_REQ, and leaves DIN and CMT_DIN unchanged.
- CMT_ACK outside CMT is ignored.
- Out-of-range DIN values (> DIN_MAX) are unreachable. After reset or any update, DIN is always <= DIN_MAX.

Optional Feature:
- Macro: FACT_AUTOREPEAT_EN.
- Defined: while up or down is held in SEL, an extra step pulse is generated after REPEAT_DLY cycles, then every REPEAT_PER cycles, until release. Each button has its own hold counter, cleared on release or on leaving SEL.
- Undefined: exactly one step per press; no hold counters are synthesised.

Decomposition:
- Shared package fact_pkg: STATE encodings (ST_READY=4'b0010, ST_INPUT=4'b0100), the FSM state typedef (IDLE/SEL/CMT/REL), and the DIN_MAX default.
- One sub-module, btn_debounce: synchroniser + counter, outputs the clean level and the press pulse. Instantiated three times.

Test Plan (simulation: DEB_CYCLES=4, REPEAT_DLY=20, REPEAT_PER=8):
- Reset mid-press: nRST=0 while nBTN_UP held low -> DIN=0, CMT_REQ=0 immediately. After release of reset with the button still low, one press pulse arrives after 6 cycles, then DIN=1.
- Bounce rejection: STATE=4'b0100, nBTN_UP toggles every 2 cycles for 20 cycles, then stays low -> exactly one increment; DIN 0->1.
- Wrap: from DIN=9, press up -> DIN=0. Press down -> DIN=9.
- Commit handshake: DIN=3, press OK -> CMT_REQ=1, CMT_DIN=3, BUSY=1. Up presses are ignored. CMT_ACK pulse -> CMT_REQ=0, DIN=0. OK held keeps the block in REL; release returns it to SEL.
- State gating: STATE=4'b0010, press up 3 times -> DIN unchanged. STATE changes to 4'b0010 during CMT -> CMT_REQ drops the next cycle.
- FACT_AUTOREPEAT_EN: hold up for 6+20+2*8 cycles from DIN=0 -> DIN=3. Without the macro, the same stimulus gives DIN=1.
